alu_mul_sequencer: RTL and testbench

- Multi-cycle controller that computes the low N bits of an unsigned N×N product by sequencing a shared, external combinational LEGv8 ALU through shift-add iterations.
- Drives the ALU's A, B, FS and C0 inputs and captures its F and status outputs each cycle.
- Sits beside the ALU in the execute stage and is started by the control unit for MUL.
- Owns the ALU only while busy=1. The datapath mux selects these outputs only when busy=1.

---
 rtl/alu_mul_sequencer.sv | 147 ++++++++++++++
 tb/tb_alu_mul_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier controller that drives a shared external LEGv8 ALU.
// It produces the low N bits of op_a*op_b and a sticky overflow flag.
module alu_mul_sequencer #(
  parameter int unsigned N          = 64,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] op_a,
  input  logic [N-1:0] op_b,
  output logic [N-1:0] alu_A,
  output logic [N-1:0] alu_B,
  output logic [4:0]   alu_FS,
  output logic         alu_C0,
  input  logic [N-1:0] alu_F,
  input  logic [3:0]   alu_status,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         ovf
);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_SHL, S_DONE} state_t;

  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SHL = 5'b10000;

  state_t       state_q, state_d;
  logic [N-1:0] p_q, p_d;
  logic [N-1:0] m_q, m_d;
  logic [N-1:0] q_q, q_d;
  logic [6:0]   cnt_q, cnt_d;
  logic [N-1:0] result_q, result_d;
  logic         ovf_q, ovf_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic q_zero;
  logic skip_add;

  assign q_zero   = (q_q == '0);
  assign skip_add = EARLY_EXIT && q_zero;

  // The ALU is combinational, so its operands follow the current state and
  // its result is captured at the end of the same cycle.
  always_comb begin
    alu_A  = '0;
    alu_B  = '0;
    alu_FS = '0;
    unique case (state_q)
      S_ADD: begin
        if (!skip_add && q_q[0]) begin
          alu_A  = p_q;
          alu_B  = m_q;
          alu_FS = FS_ADD;
        end
      end
      S_SHL: begin
        alu_A  = m_q;
        alu_B  = N'(1);
        alu_FS = FS_SHL;
      end
      default: ;
    endcase
  end

  assign alu_C0 = 1'b0;

  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    m_d      = m_q;
    q_d      = q_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          p_d     = '0;
          m_d     = op_a;
          q_d     = op_b;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        if (skip_add) begin
          state_d = S_DONE;
        end else begin
          if (q_q[0]) begin
            p_d   = alu_F;
            ovf_d = ovf_q | alu_status[2];
          end
          state_d = S_SHL;
        end
      end
      S_SHL: begin
        m_d = alu_F;
        // A set MSB shifted out while multiplier bits remain means lost product bits.
        if (m_q[N-1] && ((q_q >> 1) != '0)) ovf_d = 1'b1;
        q_d     = q_q >> 1;
        cnt_d   = cnt_q + 7'd1;
        state_d = (cnt_q == 7'(N - 1)) ? S_DONE : S_ADD;
      end
      S_DONE: begin
        result_d = p_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      p_q      <= '0;
      m_q      <= '0;
      q_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      m_q      <= m_d;
      q_q      <= q_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a behavioural ALU attached to
// each of two instances (early exit enabled and disabled).
module tb_alu_mul_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [63:0] op_a = '0, op_b = '0;

  logic [63:0] A0, B0, F0, res0, A1, B1, F1, res1;
  logic [4:0]  FS0, FS1;
  logic        C00, C01;
  logic [3:0]  st0, st1;
  logic        busy0, done0, ovf0, busy1, done1, ovf1;
  logic [64:0] r0, r1;

  always #5 clock = ~clock;

  function automatic logic [64:0] alu_model(input logic [63:0] a, input logic [63:0] b,
                                            input logic [4:0] fs, input logic c0);
    case (fs)
      5'b01000: return {1'b0, a} + {1'b0, b} + {64'd0, c0};
      5'b10000: return {1'b0, a << b[5:0]};
      default:  return {1'b0, a & b};
    endcase
  endfunction

  assign r0  = alu_model(A0, B0, FS0, C00);
  assign F0  = r0[63:0];
  assign st0 = {1'b0, r0[64], r0[63], r0[63:0] == 64'd0};
  assign r1  = alu_model(A1, B1, FS1, C01);
  assign F1  = r1[63:0];
  assign st1 = {1'b0, r1[64], r1[63], r1[63:0] == 64'd0};

  alu_mul_sequencer #(.N(64), .EARLY_EXIT(1'b1)) dut0 (
    .clock(clock), .reset_n(reset_n), .start(start0), .op_a(op_a), .op_b(op_b),
    .alu_A(A0), .alu_B(B0), .alu_FS(FS0), .alu_C0(C00), .alu_F(F0), .alu_status(st0),
    .busy(busy0), .done(done0), .result(res0), .ovf(ovf0));

  alu_mul_sequencer #(.N(64), .EARLY_EXIT(1'b0)) dut1 (
    .clock(clock), .reset_n(reset_n), .start(start1), .op_a(op_a), .op_b(op_b),
    .alu_A(A1), .alu_B(B1), .alu_FS(FS1), .alu_C0(C01), .alu_F(F1), .alu_status(st1),
    .busy(busy1), .done(done1), .result(res1), .ovf(ovf1));

  int unsigned ntot = 0, npass = 0, nfail = 0;
  logic [4:0]  fs_log [0:15];
  int          fs_n;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntot++;
    assert (got === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input bit sel, input logic [63:0] a, input logic [63:0] b,
                        input string tag, input int exp_lat,
                        input logic [63:0] exp_res, input logic exp_ovf);
    int   cyc;
    logic c0_seen;
    @(negedge clock);
    op_a = a; op_b = b;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clock);
    start0 = 1'b0; start1 = 1'b0;
    chk({tag, "_busy_run"}, 64'(sel ? busy1 : busy0), 64'd1);
    cyc = 1; fs_n = 0; c0_seen = 1'b0;
    while (1) begin
      if ((sel ? done1 : done0) || cyc > 300) break;
      if (fs_n < 16) fs_log[fs_n] = sel ? FS1 : FS0;
      fs_n++;
      c0_seen = c0_seen | (sel ? C01 : C00);
      @(negedge clock);
      cyc++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    chk({tag, "_c0"}, 64'(c0_seen), 64'd0);
    @(negedge clock);
    chk({tag, "_result"}, sel ? res1 : res0, exp_res);
    chk({tag, "_ovf"}, 64'(sel ? ovf1 : ovf0), 64'(exp_ovf));
    chk({tag, "_done_pulse"}, 64'(sel ? done1 : done0), 64'd0);
    chk({tag, "_busy_idle"}, 64'(sel ? busy1 : busy0), 64'd0);
  endtask

  initial begin
    int ndone, dcyc;
    logic [4:0] exp_fs [0:6];
    exp_fs[0] = 5'b01000; exp_fs[1] = 5'b10000; exp_fs[2] = 5'b00000;
    exp_fs[3] = 5'b10000; exp_fs[4] = 5'b01000; exp_fs[5] = 5'b10000;
    exp_fs[6] = 5'b00000;

    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_busy0", 64'(busy0), 64'd0);
    chk("rst_done0", 64'(done0), 64'd0);
    chk("rst_result0", res0, 64'd0);
    chk("rst_ovf0", 64'(ovf0), 64'd0);
    chk("rst_fs0", 64'(FS0), 64'd0);
    chk("rst_busy1", 64'(busy1), 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // 3*5 with early exit
    run_op(1'b0, 64'd3, 64'd5, "mul3x5", 8, 64'd15, 1'b0);
    chk("mul3x5_fs_count", 64'(fs_n), 64'd7);
    for (int i = 0; i < 7; i++) chk($sformatf("mul3x5_fs%0d", i), 64'(fs_log[i]), 64'(exp_fs[i]));
    repeat (3) @(negedge clock);
    chk("mul3x5_result_held", res0, 64'd15);

    // Reset during SHL aborts without a done pulse
    @(negedge clock);
    op_a = 64'd3; op_b = 64'd5; start0 = 1'b1;
    @(negedge clock);
    start0 = 1'b0;
    @(negedge clock);
    chk("abort_in_shl", 64'(FS0), 64'(5'b10000));
    reset_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy0), 64'd0);
    chk("abort_done", 64'(done0), 64'd0);
    chk("abort_result", res0, 64'd0);
    chk("abort_ovf", 64'(ovf0), 64'd0);
    chk("abort_alu_A", A0, 64'd0);
    chk("abort_alu_B", B0, 64'd0);
    chk("abort_alu_FS", 64'(FS0), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (done0 || busy0) ndone++;
    end
    chk("abort_no_activity", 64'(ndone), 64'd0);
    run_op(1'b0, 64'd3, 64'd5, "after_abort", 8, 64'd15, 1'b0);

    // Zero multiplier exits immediately without ALU ops
    run_op(1'b0, 64'h1234, 64'd0, "mul_by_zero", 2, 64'd0, 1'b0);
    chk("mul_by_zero_fs_count", 64'(fs_n), 64'd1);
    chk("mul_by_zero_fs", 64'(fs_log[0]), 64'd0);

    run_op(1'b0, 64'h1_0000_0000, 64'h1_0000_0000, "mul2p32", 68, 64'd0, 1'b1);
    run_op(1'b0, 64'h8000_0000_0000_0000, 64'd1, "mul2p63x1", 4, 64'h8000_0000_0000_0000, 1'b0);

    // Full-length runs without early exit
    run_op(1'b1, 64'd7, 64'h8000_0000_0000_0000, "noexit7", 129, 64'h8000_0000_0000_0000, 1'b1);
    run_op(1'b1, 64'd3, 64'd5, "noexit3x5", 129, 64'd15, 1'b0);

    // start held high throughout a 5*6 run
    @(negedge clock);
    op_a = 64'd5; op_b = 64'd6; start0 = 1'b1;
    ndone = 0; dcyc = 0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clock);
      if (done0) begin ndone++; dcyc = i; end
    end
    chk("hammer_done_count", 64'(ndone), 64'd1);
    chk("hammer_done_cycle", 64'(dcyc), 64'd8);
    chk("hammer_idle_gap", 64'(busy0), 64'd0);
    chk("hammer_result", res0, 64'd30);
    @(negedge clock);
    start0 = 1'b0;
    chk("hammer_reaccept", 64'(busy0), 64'd1);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done0) begin ndone = 1; break; end
      @(negedge clock);
    end
    chk("hammer_second_done", 64'(ndone), 64'd1);
    @(negedge clock);
    chk("hammer_second_result", res0, 64'd30);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
